// File: rtl/bic_decoder_if.sv
// rtl/bic_decoder_if.sv - Link-side and output-side handshake bundle for bic_decoder.
interface bic_decoder_if #(
  parameter int WIDTH = 8
);
  logic             bus_valid;
  logic             bus_ready;
  logic [WIDTH-1:0] bus_data;
  logic             bus_inv;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  modport master (
    output bus_valid, bus_data, bus_inv, out_ready,
    input  bus_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  bus_valid, bus_data, bus_inv, out_ready,
    output bus_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/bic_decoder.sv
// rtl/bic_decoder.sv - Bus-invert decoder with Hamming-rule check and 2-entry output buffer.
// Optional link statistics counters enabled by BIC_DEC_STATS_EN.
module bic_decoder #(
  parameter int WIDTH  = 8,
  parameter int THRESH = WIDTH / 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  bic_decoder_if.slave     link,
  input  logic             clr,
  output logic             err_sticky,
  output logic [CNT_W-1:0] stat_words,
  output logic [CNT_W-1:0] stat_invs,
  output logic [CNT_W-1:0] stat_toggles
);

  // Wide enough for a count over WIDTH+1 lines, so it also serves the toggle counter.
  localparam int HD_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state, state_next;
  logic             ready, valid, accept, pop;
  logic [WIDTH-1:0] dec, prev_dec;
  logic [HD_W-1:0]  hd;
  logic             exp_inv, err;
  logic [WIDTH-1:0] e0_data, e1_data;
  logic             e0_err, e1_err;

  function automatic logic [HD_W-1:0] popcount(input logic [WIDTH:0] v);
    logic [HD_W-1:0] c;
    c = '0;
    for (int i = 0; i <= WIDTH; i++) c = c + HD_W'(v[i]);
    return c;
  endfunction

  always_comb begin
    dec     = link.bus_inv ? ~link.bus_data : link.bus_data;
    hd      = popcount({1'b0, dec ^ prev_dec});
    exp_inv = (int'(hd) > THRESH);
    err     = (link.bus_inv != exp_inv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = (state != TWO);
    valid      = (state != EMPTY);
    accept     = link.bus_valid && ready;
    pop        = valid && link.out_ready;
    case (state)
      EMPTY: if (accept) state_next = ONE;
      ONE: begin
        if (accept && !pop)      state_next = TWO;
        else if (pop && !accept) state_next = EMPTY;
      end
      TWO:     if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  assign link.bus_ready = ready;
  assign link.out_valid = valid;
  assign link.out_data  = e0_data;
  assign link.out_err   = e0_err;

  // e0 is always the head; e1 only holds the second word while in TWO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_data    <= '0;
      e0_err     <= 1'b0;
      e1_data    <= '0;
      e1_err     <= 1'b0;
      prev_dec   <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (accept) prev_dec <= dec;
      if (accept && err) err_sticky <= 1'b1;
      else if (clr)      err_sticky <= 1'b0;
      case (state)
        EMPTY: begin
          if (accept) begin
            e0_data <= dec;
            e0_err  <= err;
          end
        end
        ONE: begin
          if (accept && pop) begin
            e0_data <= dec;
            e0_err  <= err;
          end else if (accept) begin
            e1_data <= dec;
            e1_err  <= err;
          end
        end
        TWO: begin
          if (pop) begin
            e0_data <= e1_data;
            e0_err  <= e1_err;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BIC_DEC_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH:0]   prev_bus;
  logic [HD_W-1:0]  tog;
  logic [CNT_W:0]   tog_sum;
  logic [CNT_W-1:0] words_q, invs_q, toggles_q;

  always_comb begin
    tog     = popcount({link.bus_inv, link.bus_data} ^ prev_bus);
    tog_sum = {1'b0, toggles_q} + (CNT_W+1)'(tog);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_bus  <= '0;
      words_q   <= '0;
      invs_q    <= '0;
      toggles_q <= '0;
    end else begin
      if (accept) prev_bus <= {link.bus_inv, link.bus_data};
      if (clr) begin
        words_q   <= '0;
        invs_q    <= '0;
        toggles_q <= '0;
      end else if (accept) begin
        if (words_q != CNT_MAX)                  words_q <= words_q + 1'b1;
        if (link.bus_inv && (invs_q != CNT_MAX)) invs_q  <= invs_q + 1'b1;
        toggles_q <= tog_sum[CNT_W] ? CNT_MAX : tog_sum[CNT_W-1:0];
      end
    end
  end

  assign stat_words   = words_q;
  assign stat_invs    = invs_q;
  assign stat_toggles = toggles_q;
`else
  assign stat_words   = '0;
  assign stat_invs    = '0;
  assign stat_toggles = '0;
`endif

endmodule

// File: doc/bic_decoder.md
Name: bic_decoder

Overview:
- Receive-side counterpart of the bus-invert encoder.
- Accepts an encoded bus word plus invert line over a valid/ready handshake, restores the original data, and checks that the sender's invert decision follows the same Hamming rule.
- Two-entry output buffer decouples the link from downstream back-pressure.
- Optionally counts link activity (words, inversions, bus-line toggles) so switched-capacitance savings can be measured in silicon.

Parameters:
- WIDTH, 8, data bus width in bits (even, >=2).
- THRESH, WIDTH/2, invert is expected when Hamming distance > THRESH.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bus_valid  input  1  encoded word present on the link.
- bus_ready  output  1  decoder can accept a word.
- bus_data  input  WIDTH  encoded (possibly inverted) data lines.
- bus_inv  input  1  invert line from the encoder.
- out_valid  output  1  decoded word available.
- out_ready  input  1  downstream accepts the decoded word.
- out_data  output  WIDTH  restored data.
- out_err  output  1  word's invert flag disagreed with the Hamming rule (qualified by out_valid).
- err_sticky  output  1  set on any accepted erroneous word; cleared by clr.
- clr  input  1  synchronous clear of err_sticky and statistics counters.
- stat_words  output  CNT_W  accepted word count.
- stat_invs  output  CNT_W  accepted words with bus_inv=1.
- stat_toggles  output  CNT_W  cumulative line toggles across WIDTH+1 link lines.

Behaviour:
- Reset values: bus_ready=1, out_valid=0, out_data=0, out_err=0, err_sticky=0, all counters 0. The internal prev_dec and prev_bus registers (WIDTH+1 bits incl. invert) are also reset to 0.
- Accept: the word is taken when bus_valid && bus_ready at a rising edge.
- Decode: dec = bus_inv ? ~bus_data : bus_data.
- Error check: hd = popcount(dec ^ prev_dec), computed at width clog2(WIDTH)+1 with no overflow. expected_inv = (hd > THRESH). err = (bus_inv != expected_inv).
- History update: on accept, prev_dec <= dec and prev_bus <= {bus_inv, bus_data}. Both update on every accepted word, including erroneous ones.
- Buffer: 2-entry FIFO holding {dec, err}. States are EMPTY, ONE, TWO.
  - EMPTY -> ONE on accept.
  - ONE -> TWO on accept without pop.
  - ONE -> EMPTY on pop without accept.
  - ONE stays ONE on simultaneous accept and pop.
  - TWO -> ONE on pop.
- bus_ready = (state != TWO). This is registered: in TWO, a same-cycle pop does not allow a same-cycle accept.
- out_valid = (state != EMPTY). out_data/out_err always show the head entry. They hold stable while out_valid && !out_ready.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N (one cycle), when the buffer was EMPTY.
- Ordering: words leave strictly in acceptance order, none dropped or duplicated.
- err_sticky is set on the edge that accepts an erroneous word.
- clr vs. error: clr and an erroneous accept in the same cycle leave err_sticky=1 (set wins).
- Reset mid-operation: asynchronous reset discards buffered words immediately and returns history to 0. Encoder and decoder must be reset together.

Optional Feature:
- Macro: BIC_DEC_STATS_EN.
- Defined:
  - stat_words increments on each accept.
  - stat_invs increments on each accept with bus_inv=1.
  - stat_toggles += popcount({bus_inv,bus_data} ^ prev_bus) on each accept.
  - All counters saturate at 2^CNT_W-1 (no wrap).
  - clr zeroes all counters, and wins over a same-cycle increment.
- Not defined: all three counter outputs are tied to 0 and no counter flops exist. err_sticky and clr behave identically in both builds.

Test Plan:
- After reset, send bus_data=0x0F, bus_inv=0 (hd=4 vs 0x00) -> out_data=0x0F, out_err=0, one cycle later.
- Next send bus_data=0x0F, bus_inv=1 (dec=0xF0, hd=8 vs 0x0F) -> out_data=0xF0, out_err=0. With stats: stat_invs=1, stat_toggles=5 (4+1 from 0x0F/0, then 1 for the inv line only).
- Send bus_data=0x1F, bus_inv=0 after prev_dec=0x00 (hd=5, inversion expected) -> out_err=1, err_sticky=1. Then clr=1 -> err_sticky=0.
- Hold out_ready=0 and offer 3 words -> bus_ready drops after 2 accepts and the third waits. Release out_ready -> all three emerge in order with data unchanged.
- Stream 10 words with out_ready toggling every cycle -> no loss or reordering, out_data stable while stalled.
- Assert rst_n low while buffer is in state TWO -> out_valid=0 and bus_ready=1 immediately. Next word is compared against prev_dec=0x00.
